// File: rtl/riscv_irq_pending_if.sv
// Signal bundle between the interrupt sources/core control and the
// interrupt pending stage. The slave side is the pending stage itself.
interface riscv_irq_pending_if #(
  parameter int NUM_IRQ = 32
);
  logic [NUM_IRQ-1:0] irq_src_i;
  logic [NUM_IRQ-1:0] edge_sel_i;
  logic [NUM_IRQ-1:0] mask_i;
  logic               sw_set_i;
  logic [4:0]         sw_set_id_i;
  logic               ack_i;
  logic [4:0]         ack_id_i;
  logic               clr_overrun_i;
  logic [NUM_IRQ-1:0] irq_o;
  logic               irq_valid_o;
  logic [4:0]         irq_id_o;
  logic [NUM_IRQ-1:0] overrun_o;

  modport master (
    output irq_src_i, edge_sel_i, mask_i, sw_set_i, sw_set_id_i,
           ack_i, ack_id_i, clr_overrun_i,
    input  irq_o, irq_valid_o, irq_id_o, overrun_o
  );

  modport slave (
    input  irq_src_i, edge_sel_i, mask_i, sw_set_i, sw_set_id_i,
           ack_i, ack_id_i, clr_overrun_i,
    output irq_o, irq_valid_o, irq_id_o, overrun_o
  );
endinterface

// File: rtl/riscv_irq_pending.sv
// Interrupt capture/pending stage: synchronises raw sources, captures edges
// into sticky pending bits (or passes levels), tracks overruns, and presents
// a masked vector with a lowest-index-wins ID to the exception controller.
module riscv_irq_pending #(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  riscv_irq_pending_if.slave bus
);

  logic [NUM_IRQ-1:0] sync_chain [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] sw_hit;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] overrun_q;
  logic [NUM_IRQ-1:0] overrun_d;
  logic [NUM_IRQ-1:0] irq;
  logic [4:0]         irq_id;

  assign sync = sync_chain[SYNC_STAGES-1];
  assign rise = sync & ~sync_prev;

  // Synchroniser chain plus the delayed copy used for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_chain[k] <= '0;
      sync_prev <= '0;
    end else begin
      sync_chain[0] <= bus.irq_src_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_chain[k] <= sync_chain[k-1];
      sync_prev <= sync;
    end
  end

  // Per-line hit decode and next-state terms. IDs at or above NUM_IRQ
  // simply never match a line.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    assign sw_hit[gi]  = bus.sw_set_i & (bus.sw_set_id_i == 5'(gi));
    assign ack_hit[gi] = bus.ack_i    & (bus.ack_id_i    == 5'(gi));

    // A set on the same cycle as an ack wins so no event is lost.
    assign pending_d[gi] = bus.edge_sel_i[gi]
                         ? ((pending_q[gi] & ~ack_hit[gi]) | rise[gi] | sw_hit[gi])
                         : sync[gi];

    // Overrun set has priority over the global clear.
    assign overrun_d[gi] = (bus.edge_sel_i[gi] & (rise[gi] | sw_hit[gi]) &
                            pending_q[gi] & ~ack_hit[gi])
                         | (overrun_q[gi] & ~bus.clr_overrun_i);
  end

  // Pending and overrun state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq = pending_q & bus.mask_i;

  // Lowest set index wins, matching the downstream cause encoding.
  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) irq_id = 5'(i);
    end
  end

  assign bus.irq_o       = irq;
  assign bus.irq_valid_o = |irq;
  assign bus.irq_id_o    = irq_id;
  assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_riscv_irq_pending.sv
// Self-checking bench for riscv_irq_pending: directed scenarios followed by
// randomized traffic, compared against a delay-line reference model.
module tb_riscv_irq_pending;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_irq_pending_if #(.NUM_IRQ(32)) bus32 ();
  riscv_irq_pending_if #(.NUM_IRQ(8))  bus8 ();

  riscv_irq_pending #(.NUM_IRQ(32), .SYNC_STAGES(S)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );
  riscv_irq_pending #(.NUM_IRQ(8), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: hist[k] is the source vector sampled k+1 edges ago.
  bit [31:0] hist [0:S];
  bit [31:0] m_pend;
  bit [31:0] m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k <= S; k++) hist[k] = '0;
    m_pend = '0;
    m_ovr  = '0;
  endtask

  // One clock edge of the spec's rules, using the inputs present at the edge.
  task automatic model_edge();
    bit [31:0] s, p;
    bit swh, ackh, ev;
    s = hist[S-1];
    p = hist[S];
    for (int i = 0; i < 32; i++) begin
      swh  = bus32.sw_set_i && (int'(bus32.sw_set_id_i) == i);
      ackh = bus32.ack_i    && (int'(bus32.ack_id_i)    == i);
      if (bus32.edge_sel_i[i]) begin
        ev = (s[i] && !p[i]) || swh;
        if (ev && m_pend[i] && !ackh) m_ovr[i] = 1'b1;
        else if (bus32.clr_overrun_i) m_ovr[i] = 1'b0;
        m_pend[i] = (m_pend[i] && !ackh) || ev;
      end else begin
        if (bus32.clr_overrun_i) m_ovr[i] = 1'b0;
        m_pend[i] = s[i];
      end
    end
    for (int k = S; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = bus32.irq_src_i;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    bit [31:0] e;
    e = m_pend & bus32.mask_i;
    chk({tag, ".irq"},     bus32.irq_o,              e);
    chk({tag, ".valid"},   32'(bus32.irq_valid_o),   32'(e != 0));
    chk({tag, ".id"},      32'(bus32.irq_id_o),      32'(lowest(e)));
    chk({tag, ".overrun"}, bus32.overrun_o,          m_ovr);
  endtask

  task automatic idle_inputs();
    bus32.sw_set_i = 1'b0; bus32.sw_set_id_i = '0;
    bus32.ack_i = 1'b0;    bus32.ack_id_i = '0;
    bus32.clr_overrun_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int cnt;
  int first;

  initial begin
    model_clear();
    bus32.irq_src_i = '1; bus32.edge_sel_i = '0; bus32.mask_i = '1;
    idle_inputs();
    bus8.irq_src_i = '0; bus8.edge_sel_i = '1; bus8.mask_i = '1;
    bus8.sw_set_i = 1'b0; bus8.sw_set_id_i = '0; bus8.ack_i = 1'b0;
    bus8.ack_id_i = '0; bus8.clr_overrun_i = 1'b0;

    // 1. Reset values with all sources high, then rise seen on release.
    rst = 1'b1;
    tick(); tick();
    chk("rst.irq", bus32.irq_o, 32'h0);
    chk("rst.valid", 32'(bus32.irq_valid_o), 32'h0);
    chk("rst.id", 32'(bus32.irq_id_o), 32'h0);
    chk("rst.overrun", bus32.overrun_o, 32'h0);
    bus32.irq_src_i = 32'h8; bus32.edge_sel_i = 32'h8;
    rst = 1'b0;
    tick(); check_all("rel1");
    tick(); check_all("rel2");
    chk("rel2.irq_zero", bus32.irq_o, 32'h0);
    tick(); check_all("rel3");
    chk("rel3.irq", bus32.irq_o, 32'h8);
    chk("rel3.id", 32'(bus32.irq_id_o), 32'd3);
    bus32.irq_src_i = '0;

    // 2. Edge capture on line 5: 3-cycle pulse, latency 2, then ack.
    do_reset();
    bus32.edge_sel_i = 32'h20;
    bus32.irq_src_i = 32'h20;
    for (int t = 0; t < 6; t++) begin
      if (t == 3) bus32.irq_src_i = '0;
      tick(); check_all("edge5");
      chk("edge5.bit", 32'(bus32.irq_o[5]), 32'(t >= 2));
    end
    bus32.ack_i = 1'b1; bus32.ack_id_i = 5'd5;
    tick(); idle_inputs();
    check_all("ack5");
    chk("ack5.bit", 32'(bus32.irq_o[5]), 32'h0);

    // 3. Level follow on line 0 for 10 cycles; ack has no effect.
    do_reset();
    bus32.edge_sel_i = '0;
    bus32.irq_src_i = 32'h1;
    cnt = 0; first = -1;
    for (int t = 0; t < 16; t++) begin
      if (t == 10) bus32.irq_src_i = '0;
      if (t == 6) begin bus32.ack_i = 1'b1; bus32.ack_id_i = 5'd0; end
      tick(); idle_inputs();
      check_all("level0");
      if (t == 6) chk("level0.ack_noeffect", 32'(bus32.irq_o[0]), 32'h1);
      if (bus32.irq_o[0]) begin
        cnt++;
        if (first < 0) first = t;
      end
    end
    chk("level0.count", 32'(cnt), 32'd10);
    chk("level0.first", 32'(first), 32'd2);

    // 4. Priority and mask on lines 7 and 12.
    do_reset();
    bus32.edge_sel_i = '1;
    bus32.sw_set_i = 1'b1; bus32.sw_set_id_i = 5'd12; tick();
    bus32.sw_set_id_i = 5'd7; tick(); idle_inputs();
    check_all("prio");
    chk("prio.id7", 32'(bus32.irq_id_o), 32'd7);
    bus32.mask_i[7] = 1'b0; #1;
    check_all("mask7off");
    chk("mask7off.id12", 32'(bus32.irq_id_o), 32'd12);
    bus32.mask_i[7] = 1'b1; #1;
    chk("mask7on.id7", 32'(bus32.irq_id_o), 32'd7);

    // 5. Simultaneous ack/set on line 9, overrun and clear.
    do_reset();
    bus32.sw_set_i = 1'b1; bus32.sw_set_id_i = 5'd9; tick();
    bus32.ack_i = 1'b1; bus32.ack_id_i = 5'd9; tick(); idle_inputs();
    check_all("setack9");
    chk("setack9.pend", 32'(bus32.irq_o[9]), 32'h1);
    chk("setack9.ovr", 32'(bus32.overrun_o[9]), 32'h0);
    bus32.sw_set_i = 1'b1; bus32.sw_set_id_i = 5'd9; tick(); idle_inputs();
    check_all("ovr9");
    chk("ovr9.set", 32'(bus32.overrun_o[9]), 32'h1);
    bus32.clr_overrun_i = 1'b1; tick(); idle_inputs();
    check_all("clr9");
    chk("clr9.ovr", 32'(bus32.overrun_o[9]), 32'h0);

    // 6. Out-of-range IDs on the 8-line instance.
    bus8.sw_set_i = 1'b1; bus8.sw_set_id_i = 5'd1; tick();
    bus8.sw_set_id_i = 5'd4; tick();
    bus8.sw_set_id_i = 5'd20; bus8.ack_i = 1'b1; bus8.ack_id_i = 5'd20; tick();
    bus8.sw_set_id_i = 5'd8; bus8.ack_id_i = 5'd8; tick();
    bus8.sw_set_i = 1'b0; bus8.ack_i = 1'b0;
    chk("oor.irq", 32'(bus8.irq_o), 32'h12);
    chk("oor.id", 32'(bus8.irq_id_o), 32'd1);
    chk("oor.ovr", 32'(bus8.overrun_o), 32'h0);

    // 7. Randomized traffic against the model, with one mid-run reset.
    do_reset();
    check_all("rnd.rst");
    for (int t = 0; t < 400; t++) begin
      if (t == 200) begin
        rst = 1'b1; #1;
        chk("rnd.async_rst", bus32.irq_o, 32'h0);
        tick(); rst = 1'b0;
      end
      if (t % 50 == 0) bus32.edge_sel_i = $urandom;
      bus32.irq_src_i = bus32.irq_src_i ^ ($urandom & $urandom & $urandom);
      bus32.mask_i = $urandom | $urandom;
      bus32.sw_set_i = ($urandom_range(0, 3) == 0);
      bus32.sw_set_id_i = 5'($urandom_range(0, 31));
      bus32.ack_i = ($urandom_range(0, 2) == 0);
      bus32.ack_id_i = $urandom_range(0, 1) ? bus32.irq_id_o : 5'($urandom_range(0, 31));
      bus32.clr_overrun_i = ($urandom_range(0, 15) == 0);
      tick();
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/riscv_irq_pending.md
# riscv_irq_pending

Interrupt capture and pending stage that sits directly upstream of the exception controller and drives its level-triggered `irq_i[31:0]` vector. Each raw, asynchronous interrupt source is synchronised, then either edge-captured into a sticky pending bit or passed through as a level. The result is masked per line and presented with a lowest-index-wins ID. Edge-mode pending bits are cleared by an acknowledge issued when the core saves an interrupt cause.

## Interface
Parameters:
- `NUM_IRQ`, 32 — number of interrupt lines; legal range 1..32.
- `SYNC_STAGES`, 2 — synchroniser depth per line; legal range ≥2.

Ports:
- `clk` in 1 — core clock; the only clock.
- `rst` in 1 — asynchronous, active-high reset.
- `irq_src_i` in NUM_IRQ — raw interrupt sources, asynchronous to `clk`.
- `edge_sel_i` in NUM_IRQ — per-line mode: 1 = rising-edge capture, 0 = level.
- `mask_i` in NUM_IRQ — per-line enable; 1 = line may assert `irq_o`.
- `sw_set_i` in 1 — software pend request, valid for one cycle.
- `sw_set_id_i` in 5 — line index targeted by `sw_set_i`.
- `ack_i` in 1 — interrupt acknowledge, asserted for one cycle when the cause is saved.
- `ack_id_i` in 5 — line index being acknowledged.
- `clr_overrun_i` in 1 — clears all overrun flags.
- `irq_o` out NUM_IRQ — `pending_q & mask_i`; feeds the exception controller `irq_i`. Zero-extended to 32 bits at top level.
- `irq_valid_o` out 1 — OR-reduction of `irq_o`.
- `irq_id_o` out 5 — lowest set index of `irq_o`; 0 when none is set.
- `overrun_o` out NUM_IRQ — sticky flag per line: an edge arrived while that line was already pending.

## Operation
- **Synchroniser.** Each line of `irq_src_i` passes through a `SYNC_STAGES`-deep flop chain, giving `sync[i]`. A further flop holds `sync_prev[i]`. The rising-edge term is `rise[i] = sync[i] & ~sync_prev[i]`.
- **Hit decode.** `sw_hit[i] = sw_set_i & (sw_set_id_i == i)`. `ack_hit[i] = ack_i & (ack_id_i == i)`. An ID ≥ NUM_IRQ matches no line and is ignored.
- **Pending register, per line, updated every cycle:**
  - Edge mode: `pending_q[i] <= (pending_q[i] & ~ack_hit[i]) | rise[i] | sw_hit[i]`. A set on the same cycle as an ack wins, so a new event is never lost.
  - Level mode: `pending_q[i] <= sync[i]`. `sw_hit` and `ack_hit` have no effect on level lines.
  - Mode change: if `edge_sel_i` toggles, the new mode applies from the next edge. Switching to level overwrites the pending bit with `sync[i]`.
- **Overrun.** For an edge line, `overrun_q[i]` is set when `rise[i] | sw_hit[i]` occurs while `pending_q[i]` is 1 and `ack_hit[i]` is 0. It is held until `clr_overrun_i`. If a set condition and `clr_overrun_i` occur on the same cycle, the set wins.
- **Masking.** `mask_i` gates only the outputs. Masked lines still capture and hold their pending bits.
- **Outputs.** All outputs are combinational from registers plus `mask_i`. There is no combinational path from `irq_src_i`, `ack_i`, or `sw_set_i` to any output.
- **ID encoding.** The `irq_id_o` priority (lowest index wins) matches the cause encoding downstream, so `irq_id_o` equals the cause[4:0] the exception controller will select.

## Timing
- **Reset.** While `rst` is high, all synchroniser, `sync_prev`, `pending_q`, and `overrun_q` flops are 0. Therefore `irq_o=0`, `irq_valid_o=0`, `irq_id_o=0`, `overrun_o=0`.
- **Reset mid-operation.** All pending edges are discarded. A source that is still high at reset release is seen as a new rise once synchronised, because `sync_prev` resets to 0.
- **Source latency.** If the source is first sampled high at edge t, `irq_o[i]` is high after edge t+SYNC_STAGES, in both modes. For `SYNC_STAGES=2`, that is 2 cycles.
- **Level deassert.** Source low sampled at edge t gives `irq_o[i]` low after edge t+SYNC_STAGES.
- **Software set.** `sw_set_i` sampled at edge t gives the pending bit visible after edge t (1-cycle latency).
- **Acknowledge.** `ack_i` sampled at edge t clears the pending bit after edge t. `irq_o`, `irq_valid_o`, and `irq_id_o` update in the same cycle.
- **Edge detection limits.**
  - A source pulse shorter than one `clk` period may be missed.
  - Re-arming requires the source to be sampled low for at least 1 cycle.
  - A source held high produces exactly one rise.
- **Mask change.** Takes effect combinationally on `irq_o` in the same cycle.

## Test plan
1. **Reset values.** Assert `rst` with all `irq_src_i` high → all outputs 0. Release `rst` with line 3 in edge mode and the source still high → after 2 cycles `irq_o=32'h8`, `irq_id_o=3`.
2. **Edge capture, latency, and ack.** Line 5 in edge mode; pulse the source for 3 cycles → `irq_o[5]` rises exactly 2 cycles after first sample and stays high after the source drops. `ack_i=1, ack_id_i=5` → `irq_o[5]=0` the next cycle.
3. **Level follow.** Line 0 in level mode; hold the source high for 10 cycles → `irq_o[0]` is high for exactly 10 cycles, delayed by 2. An ack on line 0 while high → no effect.
4. **Priority and mask.** Pend lines 7 and 12 → `irq_id_o=7`. Clear `mask_i[7]` → `irq_id_o=12` in the same cycle. Set `mask_i[7]` again → `irq_id_o=7`, with bit 7 still pending.
5. **Simultaneous ack and set, plus overrun.** Line 9 pending; `sw_set` on line 9 and ack on line 9 in the same cycle → line 9 remains pending and `overrun_o[9]=0`. A second `sw_set` on line 9 with no ack → `overrun_o[9]=1`. `clr_overrun_i` → `overrun_o[9]=0`.
6. **Out-of-range IDs.** With `NUM_IRQ=8`: `sw_set_id_i=20` and `ack_id_i=20` → no state change on any line.
